// File: rtl/cache_req_pkg.sv
// Shared types and constants for the CPU-to-cache request initiator.
package cache_req_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;

   localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } cache_req_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [MASK_W-1:0] rmask;
      logic [MASK_W-1:0] wmask;
      logic [DATA_W-1:0] wdata;
   } cache_req_t;

endpackage

// File: rtl/cache_rsp_buf.sv
// One-entry response skid buffer: holds load data while the pipeline stalls.
module cache_rsp_buf
   import cache_req_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data
);

   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_data <= '0;
      end else if (i_clear) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/cache_req_initiator.sv
// Requester-side driver for the CPU-to-cache port, one request outstanding.
// Optional BUSY watchdog compiled in with CACHE_REQ_TIMEOUT_EN.
module cache_req_initiator
   import cache_req_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [MASK_W-1:0] req_rmask,
   input  logic [MASK_W-1:0] req_wmask,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [MASK_W-1:0] mem_rmask,
   output logic [MASK_W-1:0] mem_wmask,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              timeout_err
);

   cache_req_state_t  r_state;
   cache_req_state_t  w_next_state;
   cache_req_t        r_mem;
   cache_req_t        w_req;
   logic              w_has_mask;
   logic              w_accept;
   logic              w_req_ready;
   logic              w_rsp_valid;
   logic [DATA_W-1:0] w_rsp_rdata;
   logic [DATA_W-1:0] w_resp_data;
   logic [DATA_W-1:0] w_buf_data;
   logic              w_buf_load;
   logic              w_buf_clear;

   // Cache-facing view of the incoming request; a store mask overrides the read mask.
   always_comb begin
      w_req.addr  = req_addr & WORD_ALIGN_MASK;
      w_req.rmask = (req_wmask != '0) ? '0 : req_rmask;
      w_req.wmask = req_wmask;
      w_req.wdata = req_wdata;
   end

   assign w_has_mask  = (req_rmask != '0) || (req_wmask != '0);
   assign w_resp_data = (r_mem.wmask != '0) ? '0 : mem_rdata;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_req_ready  = 1'b0;
      w_rsp_valid  = 1'b0;
      w_rsp_rdata  = '0;
      w_buf_load   = 1'b0;
      w_buf_clear  = 1'b0;
      w_accept     = 1'b0;

      case (r_state)
         IDLE: begin
            w_req_ready = 1'b1;
         end
         BUSY: begin
            if (mem_resp) begin
               w_rsp_valid = 1'b1;
               w_rsp_rdata = w_resp_data;
               if (rsp_ready) begin
                  w_req_ready  = 1'b1;
                  w_next_state = IDLE;
               end else begin
                  w_buf_load   = 1'b1;
                  w_next_state = HOLD;
               end
            end
         end
         HOLD: begin
            w_rsp_valid = 1'b1;
            w_rsp_rdata = w_buf_data;
            if (rsp_ready) begin
               w_req_ready  = 1'b1;
               w_buf_clear  = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase

      // Nothing is offered or returned to the pipeline while reset is held.
      if (!rst) begin
         w_req_ready = 1'b0;
         w_rsp_valid = 1'b0;
         w_rsp_rdata = '0;
      end

      w_accept = req_valid && w_req_ready;
      if (w_accept) begin
         if (w_has_mask) begin
            w_next_state = BUSY;
         end else begin
            w_buf_clear  = 1'b1;
            w_next_state = HOLD;
         end
      end
   end

   // Cache-side request register; masks drop as soon as the cache completes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mem <= '0;
      end else if (w_accept && w_has_mask) begin
         r_mem <= w_req;
      end else if ((r_state == BUSY) && mem_resp) begin
         r_mem.rmask <= '0;
         r_mem.wmask <= '0;
      end
   end

   cache_rsp_buf u_rsp_buf (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_buf_load),
      .i_clear (w_buf_clear),
      .i_data  (w_resp_data),
      .o_data  (w_buf_data)
   );

`ifdef CACHE_REQ_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_to_cnt;
   logic             r_timeout_err;

   // Saturating BUSY watchdog; the flag is sticky and never aborts the transaction.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else if (w_accept && w_has_mask) begin
         r_to_cnt <= '0;
      end else if ((r_state == BUSY) && !mem_resp &&
                   (r_to_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
         r_to_cnt <= r_to_cnt + CNT_W'(1);
         if (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   assign req_ready = w_req_ready;
   assign rsp_valid = w_rsp_valid;
   assign rsp_rdata = w_rsp_rdata;
   assign mem_addr  = r_mem.addr;
   assign mem_rmask = r_mem.rmask;
   assign mem_wmask = r_mem.wmask;
   assign mem_wdata = r_mem.wdata;

endmodule

// File: tb/tb_cache_req_initiator.sv
// Scoreboard bench for cache_req_initiator; timeout expectations follow CACHE_REQ_TIMEOUT_EN.
module tb_cache_req_initiator;

`ifdef CACHE_REQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [3:0]  req_rmask;
   logic [3:0]  req_wmask;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        timeout_err;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] sb_q[$];
   logic [31:0] mon_exp;

   always #5 clk = ~clk;

   cache_req_initiator #(.TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_rmask   (req_rmask),
      .req_wmask   (req_wmask),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .mem_addr    (mem_addr),
      .mem_rmask   (mem_rmask),
      .mem_wmask   (mem_wmask),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp),
      .timeout_err (timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Every completed response handshake is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            mon_exp = sb_q.pop_front();
            check("rsp_rdata", rsp_rdata, mon_exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request and wait (bounded) for the accepting edge; returns #1 after it.
   task automatic issue(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input bit push, input logic [31:0] exp);
      int n;
      n         = 0;
      req_valid = 1'b1;
      req_addr  = a;
      req_rmask = rm;
      req_wmask = wm;
      req_wdata = wd;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_accept", 32'(req_ready), 32'd1);
      if (push) sb_q.push_back(exp);
      step();
      req_valid = 1'b0;
      req_rmask = 4'd0;
      req_wmask = 4'd0;
   endtask

   // Cache model: answer after lat BUSY cycles, checking the request stays stable.
   task automatic reply(input int lat, input logic [31:0] data, input logic [31:0] a,
                        input logic [3:0] rm, input logic [3:0] wm);
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         check("hold_addr", mem_addr, a);
         check("hold_masks", {24'd0, mem_rmask, mem_wmask}, {24'd0, rm, wm});
         check("hold_no_rsp", 32'(rsp_valid), 32'd0);
         step();
      end
      mem_resp  = 1'b1;
      mem_rdata = data;
      @(negedge clk);
      check("resp_addr", mem_addr, a);
      check("resp_masks", {24'd0, mem_rmask, mem_wmask}, {24'd0, rm, wm});
      check("resp_valid", 32'(rsp_valid), 32'd1);
      step();
      mem_resp  = 1'b0;
      mem_rdata = 32'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0]  rm, wm;

      rst       = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'd0;
      req_rmask = 4'd0;
      req_wmask = 4'd0;
      req_wdata = 32'd0;
      rsp_ready = 1'b1;
      mem_rdata = 32'd0;
      mem_resp  = 1'b0;

      // Reset values.
      step();
      step();
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_masks", {24'd0, mem_rmask, mem_wmask}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);
      rst = 1'b1;
      step();
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 32'd1);
      step();

      // Aligned read with 3-cycle cache latency.
      issue(32'h0000_1006, 4'b1100, 4'b0000, 32'd0, 1'b1, 32'hDEAD_BEEF);
      reply(3, 32'hDEAD_BEEF, 32'h0000_1004, 4'b1100, 4'b0000);
      @(negedge clk);
      check("done_masks", {24'd0, mem_rmask, mem_wmask}, 32'd0);
      check("done_rsp_valid", 32'(rsp_valid), 32'd0);
      check("done_addr_kept", mem_addr, 32'h0000_1004);
      step();

      // Store followed back-to-back by a read of the same word.
      issue(32'h0000_0040, 4'b0000, 4'b1111, 32'h1234_5678, 1'b1, 32'd0);
      @(negedge clk);
      check("wr_masks", {24'd0, mem_rmask, mem_wmask}, {24'd0, 4'b0000, 4'b1111});
      check("wr_wdata", mem_wdata, 32'h1234_5678);
      step();
      mem_resp  = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      req_valid = 1'b1;
      req_addr  = 32'h0000_0040;
      req_rmask = 4'b1111;
      req_wmask = 4'b0000;
      sb_q.push_back(32'h0BAD_F00D);
      @(negedge clk);
      check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
      check("b2b_req_ready", 32'(req_ready), 32'd1);
      step();
      mem_resp  = 1'b0;
      req_valid = 1'b0;
      req_rmask = 4'd0;
      reply(2, 32'h0BAD_F00D, 32'h0000_0040, 4'b1111, 4'b0000);

      // Both masks set: write mask wins, response data is zero.
      issue(32'h0000_0087, 4'b1111, 4'b0011, 32'hAAAA_5555, 1'b1, 32'd0);
      reply(2, 32'h5555_AAAA, 32'h0000_0084, 4'b0000, 4'b0011);

      // Pipeline stalls on the response: skid into HOLD.
      rsp_ready = 1'b0;
      issue(32'h0000_0080, 4'b1111, 4'b0000, 32'd0, 1'b1, 32'hA5A5_A5A5);
      mem_resp  = 1'b1;
      mem_rdata = 32'hA5A5_A5A5;
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'hA5A5_A5A5);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      step();
      mem_resp  = 1'b0;
      mem_rdata = 32'd0;
      req_valid = 1'b1;
      req_addr  = 32'h0000_0100;
      req_rmask = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         check("hold_rsp_rdata", rsp_rdata, 32'hA5A5_A5A5);
         check("hold_req_ready", 32'(req_ready), 32'd0);
         check("hold_rmask", 32'(mem_rmask), 32'd0);
         step();
         mem_resp = (i == 1);
      end
      mem_resp  = 1'b0;
      req_valid = 1'b0;
      req_rmask = 4'd0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("release_req_ready", 32'(req_ready), 32'd1);
      step();
      @(negedge clk);
      check("release_idle", 32'(rsp_valid), 32'd0);
      check("release_masks", {24'd0, mem_rmask, mem_wmask}, 32'd0);
      step();

      // Null request: no cache activity, zero response the next cycle.
      issue(32'h0000_0300, 4'b0000, 4'b0000, 32'hFFFF_0000, 1'b1, 32'd0);
      @(negedge clk);
      check("null_rsp_valid", 32'(rsp_valid), 32'd1);
      check("null_rsp_rdata", rsp_rdata, 32'd0);
      check("null_masks", {24'd0, mem_rmask, mem_wmask}, 32'd0);
      check("null_addr_kept", mem_addr, 32'h0000_0080);
      step();
      @(negedge clk);
      check("null_done", 32'(rsp_valid), 32'd0);
      step();

      // Random reads and writes with varying cache latency.
      for (int t = 0; t < 8; t++) begin
         a  = $urandom;
         d  = $urandom;
         wm = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
         rm = 4'($urandom_range(1, 15));
         issue(a, rm, wm, d, 1'b1, (wm != 4'd0) ? 32'd0 : d);
         reply(int'($urandom_range(1, 4)), d, a & 32'hFFFF_FFFC,
               (wm != 4'd0) ? 4'd0 : rm, wm);
      end

      // Silent cache: watchdog behaviour, then late completion.
      issue(32'h0000_0500, 4'b1111, 4'b0000, 32'd0, 1'b1, 32'h7777_0000);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check("timeout_err", 32'(timeout_err), 32'(TO_EN && (k >= 9)));
         check("timeout_rmask", 32'(mem_rmask), 32'd15);
         step();
      end
      mem_resp  = 1'b1;
      mem_rdata = 32'h7777_0000;
      @(negedge clk);
      check("late_rsp_valid", 32'(rsp_valid), 32'd1);
      step();
      mem_resp = 1'b0;
      @(negedge clk);
      check("timeout_sticky", 32'(timeout_err), 32'(TO_EN));
      check("late_idle", 32'(req_ready), 32'd1);
      step();

      // Reset mid-transaction, then a stale completion pulse.
      issue(32'h0000_0200, 4'b0011, 4'b0000, 32'hCAFE_F00D, 1'b0, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rstbusy_req_ready", 32'(req_ready), 32'd0);
      step();
      rst       = 1'b1;
      mem_resp  = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check("rstbusy_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rstbusy_rsp_rdata", rsp_rdata, 32'd0);
      check("rstbusy_addr", mem_addr, 32'd0);
      check("rstbusy_wdata", mem_wdata, 32'd0);
      check("rstbusy_masks", {24'd0, mem_rmask, mem_wmask}, 32'd0);
      check("rstbusy_timeout", 32'(timeout_err), 32'd0);
      check("rstbusy_req_ready_up", 32'(req_ready), 32'd1);
      step();
      mem_resp = 1'b0;
      step();
      step();

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cache_req_initiator.md
# cache_req_initiator

Requester-side driver for the CPU-to-cache port: accepts load/store requests from a pipeline stage over valid/ready, drives `addr`/`rmask`/`wmask`/`wdata` to the cache, holds them stable until `resp`, and returns `rdata` to the pipeline over a valid/ready response channel. It sits between the memory stage and the cache, as the initiator facing the cache's `dut` port, with one request outstanding at a time.

## Interface
- `TIMEOUT_CYCLES`, default 1024: BUSY cycles without `mem_resp` before `timeout_err` asserts. Only used when the timeout feature is compiled in.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req_valid` in 1: the pipeline presents a request.
- `req_ready` out 1: the block accepts the request this cycle.
- `req_addr` in 32: byte address.
- `req_rmask` in 4: read byte mask.
- `req_wmask` in 4: write byte mask.
- `req_wdata` in 32: store data.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: the pipeline consumes the response.
- `rsp_rdata` out 32: load data. Zero for stores and null requests.
- `mem_addr` out 32: cache address, word-aligned as `{req_addr[31:2],2'b00}`.
- `mem_rmask` out 4: cache read mask.
- `mem_wmask` out 4: cache write mask.
- `mem_wdata` out 32: cache write data.
- `mem_rdata` in 32: cache read data, valid when `mem_resp` is high.
- `mem_resp` in 1: single-cycle completion pulse from the cache.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- States: IDLE, BUSY, HOLD.
- **IDLE**
  - `req_ready`=1.
  - Accept when `req_valid` is high.
  - Any nonzero mask → BUSY.
  - Both masks zero (null request) → HOLD, with buffer data 0 and no cache transaction.
- **BUSY**
  - `mem_*` outputs are registered at acceptance and held constant.
  - If both masks are nonzero, `wmask` wins and `mem_rmask` is driven 0.
  - On `mem_resp`:
    - `rsp_valid`=1 combinationally, with `rsp_rdata`=`mem_rdata` (0 if the request was a store).
    - If `rsp_ready`: the transaction completes. `req_ready`=1 in that cycle, so a new request can be accepted back-to-back and the state goes to BUSY or IDLE.
    - If not `rsp_ready`: capture the data into the one-entry buffer → HOLD.
- **HOLD**
  - `rsp_valid`=1 and `rsp_rdata` comes from the buffer.
  - `req_ready`=`rsp_ready`.
  - On `rsp_ready` the state goes to IDLE, or to BUSY if a new request is accepted in the same cycle.
- Outside BUSY, `mem_rmask` and `mem_wmask` are 0. `mem_addr` and `mem_wdata` keep their last values.
- `mem_resp` outside BUSY is ignored (a stale pulse after reset or a protocol violation).
- Responses are returned strictly in request order. At most one request is outstanding.

## Timing
- Reset (`rst`=0 at an edge):
  - State goes to IDLE.
  - `mem_addr`, `mem_rmask`, `mem_wmask`, `mem_wdata` = 0.
  - Buffer is cleared; `rsp_valid`=0, `rsp_rdata`=0.
  - `timeout_err`=0.
  - `req_ready` is forced to 0 while `rst`=0.
- Reset mid-transaction abandons it silently. No response is produced.
- Acceptance at edge N → `mem_*` masks are valid from cycle N+1.
- `mem_resp` in cycle M → `rsp_valid` in cycle M, with zero added latency.
  - A back-to-back request accepted at M is driven at M+1.
  - Masks never drop to 0 between back-to-back requests.
- Peak throughput: one request per cache latency.
- Null request: `rsp_valid` in the cycle after acceptance.
- Response handshake: `rsp_valid` and `rsp_rdata` are held stable until `rsp_ready` is high.

## Configuration
- Macro: `CACHE_REQ_TIMEOUT_EN`.
- Defined:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter clears on entry to BUSY and increments each BUSY cycle without `mem_resp`.
  - When it reaches `TIMEOUT_CYCLES`, `timeout_err` is set and stays 1 until reset. The counter saturates.
  - The transaction is not aborted; the block keeps waiting for `mem_resp`.
- Undefined: the counter is absent and `timeout_err` is tied to 0.

## Structure
- Package `cache_req_pkg`:
  - state enum `cache_req_state_t` (IDLE, BUSY, HOLD);
  - struct `cache_req_t` {addr, rmask, wmask, wdata};
  - localparam `WORD_ALIGN_MASK`=32'hFFFF_FFFC.
- Sub-module `cache_rsp_buf`: one-entry response skid buffer with load, clear and data ports. It is instantiated once.

## Test plan
- Read at 0x0000_1006 with rmask 4'b1100, cache responding after 3 cycles with 0xDEAD_BEEF and `rsp_ready`=1 → `mem_addr`=0x0000_1004 and `mem_rmask`=4'b1100 held stable for 3 cycles; `rsp_rdata`=0xDEAD_BEEF in the `mem_resp` cycle.
- Write to 0x40 with wmask 4'b1111 and data 0x1234_5678, immediately followed by a read of 0x40 → masks switch without a zero cycle; the read is driven the cycle after the write's `mem_resp`; the write's `rsp_rdata`=0.
- `rsp_ready`=0 during `mem_resp` with data 0xA5A5_A5A5 → HOLD; `req_ready`=0; the response is held for 5 cycles, then consumed on `rsp_ready`=1 → IDLE.
- Null request (both masks zero) → no cache masks asserted; `rsp_valid` the next cycle with data 0.
- `rst`=0 asserted during BUSY, followed by a stale `mem_resp` → all outputs at their reset values; no `rsp_valid`.
- With `CACHE_REQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, cache silent for 10 cycles → `timeout_err` rises after 8 BUSY cycles, stays high, and the later `mem_resp` still completes the transaction.
